sm_cfg_loader: RTL and testbench

- Serial configuration loader that sits directly upstream of the 5x4 switch-matrix routing cell.
- Hunts a sync pattern on a 1-bit config stream, then shifts in one frame of eighteen 6-bit route-select words plus a checksum.
- Validates the frame and atomically commits it to flattened config buses that drive the matrix's top/bottom/left/right select registers.
- Each route-select word is {index[5:3], side[2:0]}. Side codes: 0 = Z/disconnected, 1 = top, 2 = right, 3 = bottom, 4 = left.

---
 rtl/sm_cfg_loader.sv | 180 ++++++++++++++++++
 tb/tb_sm_cfg_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sm_cfg_loader.sv
// sm_cfg_loader
//   Serial configuration loader for the 5x4 switch-matrix routing cell.
//   Hunts an 8-bit sync pattern on a 1-bit stream, shifts in one frame of
//   route-select words plus an 8-bit checksum, validates the frame and
//   commits all words to the flattened select buses in a single edge.
//   Frame: SYNC, then words top0..topN, bottom0..bottomN, left0..leftN,
//   right0..rightN (each DW bits, MSB first), then the checksum (MSB first).
//   Route-select word = {index, side}; side 0=Z, 1=top, 2=right,
//   3=bottom, 4=left, 5..7 illegal.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   cfg_din    serial config bit
//   cfg_valid  qualifies cfg_din; low freezes all loader state
//   cfg_top    committed top words, word i at [i*DW +: DW]
//   cfg_bottom committed bottom words, same packing
//   cfg_left   committed left words, same packing
//   cfg_right  committed right words, same packing
//   busy       high while loading or checking a frame
//   cfg_done   one-cycle pulse on a successful commit
//   cfg_err    one-cycle pulse on a rejected frame
module sm_cfg_loader #(
    parameter int         NTB  = 5,
    parameter int         NLR  = 4,
    parameter int         DW   = 6,
    parameter logic [7:0] SYNC = 8'hA5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_din,
    input  logic                cfg_valid,
    output logic [NTB*DW-1:0]   cfg_top,
    output logic [NTB*DW-1:0]   cfg_bottom,
    output logic [NLR*DW-1:0]   cfg_left,
    output logic [NLR*DW-1:0]   cfg_right,
    output logic                busy,
    output logic                cfg_done,
    output logic                cfg_err
);

    localparam int             NW     = 2*NTB + 2*NLR;
    localparam int             WCW    = $clog2(NW + 1);
    localparam logic [WCW-1:0] WLAST  = WCW'(NW);
    localparam logic [2:0]     BLASTW = 3'(DW - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK
    } state_t;

    state_t         state, state_nxt;
    logic [7:0]     sync_sr;
    logic [7:0]     sum;
    logic [7:0]     rx_sum;
    logic [2:0]     bitcnt;
    logic [WCW-1:0] wordcnt;
    logic [DW-1:0]  word_sr;
    logic [DW-1:0]  word_nxt;
    logic [DW-1:0]  shadow [NW];
    logic           sync_hit;
    logic           words_legal;
    logic           frame_ok;
    logic           done_nxt;
    logic           err_nxt;

    // Sync compare includes the bit being sampled on this edge.
    assign sync_hit = ({sync_sr[6:0], cfg_din} == SYNC);
    assign word_nxt = {word_sr[DW-2:0], cfg_din};
    assign frame_ok = words_legal && (rx_sum == sum);

    always_comb begin
        words_legal = 1'b1;
        for (int unsigned i = 0; i < NW; i++) begin
            case (shadow[i][2:0])
                3'd0:       ;
                3'd1, 3'd3: if (int'(shadow[i][DW-1:3]) >= NTB) words_legal = 1'b0;
                3'd2, 3'd4: if (int'(shadow[i][DW-1:3]) >= NLR) words_legal = 1'b0;
                default:    words_legal = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cfg_valid && sync_hit) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                busy = 1'b1;
                if (cfg_valid && (wordcnt == WLAST) && (bitcnt == 3'd7))
                    state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                busy      = 1'b1;
                state_nxt = ST_IDLE;
                if (frame_ok) done_nxt = 1'b1;
                else          err_nxt  = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_sr    <= '0;
            sum        <= '0;
            rx_sum     <= '0;
            bitcnt     <= '0;
            wordcnt    <= '0;
            word_sr    <= '0;
            cfg_top    <= '0;
            cfg_bottom <= '0;
            cfg_left   <= '0;
            cfg_right  <= '0;
            cfg_done   <= 1'b0;
            cfg_err    <= 1'b0;
            for (int unsigned i = 0; i < NW; i++) shadow[i] <= '0;
        end else begin
            cfg_done <= done_nxt;
            cfg_err  <= err_nxt;
            case (state)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        sync_sr <= {sync_sr[6:0], cfg_din};
                        if (sync_hit) begin
                            bitcnt  <= '0;
                            wordcnt <= '0;
                            sum     <= '0;
                        end
                    end
                end
                ST_LOAD: begin
                    if (cfg_valid) begin
                        if (wordcnt != WLAST) begin
                            word_sr <= word_nxt;
                            if (bitcnt == BLASTW) begin
                                shadow[wordcnt] <= word_nxt;
                                sum             <= sum + 8'(word_nxt);
                                wordcnt         <= wordcnt + 1'b1;
                                bitcnt          <= '0;
                            end else begin
                                bitcnt <= bitcnt + 1'b1;
                            end
                        end else begin
                            // All words in: remaining bits are the checksum.
                            rx_sum <= {rx_sum[6:0], cfg_din};
                            bitcnt <= bitcnt + 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    sync_sr <= '0;
                    if (frame_ok) begin
                        for (int unsigned i = 0; i < NTB; i++) begin
                            cfg_top[i*DW +: DW]    <= shadow[i];
                            cfg_bottom[i*DW +: DW] <= shadow[NTB + i];
                        end
                        for (int unsigned i = 0; i < NLR; i++) begin
                            cfg_left[i*DW +: DW]   <= shadow[2*NTB + i];
                            cfg_right[i*DW +: DW]  <= shadow[2*NTB + NLR + i];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sm_cfg_loader.sv
module tb_sm_cfg_loader;

    localparam int NTB = 5;
    localparam int NLR = 4;
    localparam int DW  = 6;
    localparam int NW  = 18;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cfg_din = 1'b0;
    logic               cfg_valid = 1'b0;
    logic [NTB*DW-1:0]  cfg_top, cfg_bottom;
    logic [NLR*DW-1:0]  cfg_left, cfg_right;
    logic               busy, cfg_done, cfg_err;

    int tests = 0;
    int fails = 0;

    logic [5:0]  frame [NW];
    logic [29:0] exp_top, exp_bottom;
    logic [23:0] exp_left, exp_right;
    int          stall_prob = 0;
    int          stall_at   = -1;
    int          stall_len  = 0;

    sm_cfg_loader #(.NTB(NTB), .NLR(NLR), .DW(DW), .SYNC(8'hA5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_din    (cfg_din),
        .cfg_valid  (cfg_valid),
        .cfg_top    (cfg_top),
        .cfg_bottom (cfg_bottom),
        .cfg_left   (cfg_left),
        .cfg_right  (cfg_right),
        .busy       (busy),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: legality and checksum straight from the frame rules.
    function automatic bit word_legal(input logic [5:0] w);
        int side, idx;
        side = int'(w[2:0]);
        idx  = int'(w[5:3]);
        if (side == 0) return 1'b1;
        if (side == 1 || side == 3) return idx < NTB;
        if (side == 2 || side == 4) return idx < NLR;
        return 1'b0;
    endfunction

    function automatic logic [7:0] model_sum();
        int s = 0;
        for (int i = 0; i < NW; i++) s += int'(frame[i]);
        return 8'(s % 256);
    endfunction

    function automatic bit model_pass(input logic [7:0] cks);
        bit ok = (cks == model_sum());
        for (int i = 0; i < NW; i++) if (!word_legal(frame[i])) ok = 1'b0;
        return ok;
    endfunction

    task automatic model_commit();
        for (int i = 0; i < NTB; i++) begin
            exp_top[i*6 +: 6]    = frame[i];
            exp_bottom[i*6 +: 6] = frame[5 + i];
        end
        for (int i = 0; i < NLR; i++) begin
            exp_left[i*6 +: 6]  = frame[10 + i];
            exp_right[i*6 +: 6] = frame[14 + i];
        end
    endtask

    task automatic chk_buses(input string tag);
        chk({tag, "/top"},    64'(cfg_top),    64'(exp_top));
        chk({tag, "/bottom"}, 64'(cfg_bottom), 64'(exp_bottom));
        chk({tag, "/left"},   64'(cfg_left),   64'(exp_left));
        chk({tag, "/right"},  64'(cfg_right),  64'(exp_right));
    endtask

    task automatic tick_idle();
        cfg_valid = 1'b0;
        cfg_din   = 1'($urandom);
        @(posedge clk); #1;
    endtask

    task automatic send_bit(input logic b);
        for (int k = 0; k < 3; k++)
            if ($urandom_range(0, 99) < stall_prob) tick_idle();
        cfg_valid = 1'b1;
        cfg_din   = b;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic clear_frame();
        for (int i = 0; i < NW; i++) frame[i] = '0;
    endtask

    task automatic send_frame(input logic [7:0] cks, input string tag);
        bit pass;
        pass = model_pass(cks);
        send_byte(8'hA5);
        chk({tag, "/busy_after_sync"}, 64'(busy), 64'd1);
        for (int w = 0; w < NW; w++)
            for (int b = 0; b < DW; b++) begin
                if (stall_at == w*DW + b) begin
                    repeat (stall_len) tick_idle();
                    chk({tag, "/busy_stall"}, 64'(busy), 64'd1);
                    chk({tag, "/done_stall"}, 64'(cfg_done), 64'd0);
                end
                send_bit(frame[w][DW-1-b]);
            end
        send_byte(cks);
        // In CHECK: still busy, no pulse yet; a valid bit here must be ignored.
        chk({tag, "/busy_check"}, 64'(busy), 64'd1);
        chk({tag, "/pulse_check"}, 64'({cfg_done, cfg_err}), 64'd0);
        cfg_valid = 1'b1;
        cfg_din   = 1'($urandom);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        if (pass) model_commit();
        chk({tag, "/done"}, 64'(cfg_done), 64'(pass));
        chk({tag, "/err"},  64'(cfg_err),  64'(!pass));
        chk({tag, "/busy_after"}, 64'(busy), 64'd0);
        chk_buses(tag);
        @(posedge clk); #1;
        chk({tag, "/pulse_end"}, 64'({cfg_done, cfg_err}), 64'd0);
    endtask

    initial begin
        exp_top = '0; exp_bottom = '0; exp_left = '0; exp_right = '0;

        // Reset held three cycles with valid bits arriving.
        rst_n = 1'b0;
        cfg_valid = 1'b1;
        repeat (3) begin
            cfg_din = 1'($urandom);
            @(posedge clk);
        end
        #1;
        cfg_valid = 1'b0;
        chk_buses("reset");
        chk("reset/flags", 64'({busy, cfg_done, cfg_err}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Valid frame: top0 = right index 3.
        clear_frame();
        frame[0] = 6'b011010;
        send_frame(8'h1A, "valid");

        // Bad checksum.
        send_frame(8'h1B, "badsum");

        // Illegal index on left0.
        clear_frame();
        frame[10] = 6'b101010;
        send_frame(8'h2A, "badidx");

        // Illegal side code 7.
        clear_frame();
        frame[3] = 6'b000111;
        send_frame(8'h07, "side7");

        // Noise before sync plus a 10-cycle stall mid-word.
        clear_frame();
        frame[0] = 6'b011010;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        stall_at  = 2*DW + 3;
        stall_len = 10;
        send_frame(8'h1A, "stall");
        stall_at  = -1;

        // Payload bits 001010_010100 contain the sync pattern.
        clear_frame();
        frame[0] = 6'b001010;
        frame[1] = 6'b010100;
        send_frame(8'h1E, "payload_sync");

        // Reset after 40 payload bits, then a full all-ones frame.
        send_byte(8'hA5);
        for (int i = 0; i < 40; i++) send_bit(1'($urandom));
        rst_n = 1'b0;
        cfg_valid = 1'b1;
        cfg_din = 1'($urandom);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cfg_valid = 1'b0;
        exp_top = '0; exp_bottom = '0; exp_left = '0; exp_right = '0;
        chk("midreset/busy", 64'(busy), 64'd0);
        chk_buses("midreset");
        for (int i = 0; i < NW; i++) frame[i] = 6'b000001;
        send_frame(8'h12, "ones");

        // Randomized frames with random stalls and occasional corruption.
        stall_prob = 20;
        for (int n = 0; n < 25; n++) begin
            logic [7:0] cks;
            bit legal_mode;
            legal_mode = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NW; i++) begin
                if (legal_mode) begin
                    int side;
                    int idx;
                    side = $urandom_range(0, 4);
                    if (side == 0)                   idx = $urandom_range(0, 7);
                    else if (side == 1 || side == 3) idx = $urandom_range(0, NTB-1);
                    else                             idx = $urandom_range(0, NLR-1);
                    frame[i] = {3'(idx), 3'(side)};
                end else begin
                    frame[i] = 6'($urandom);
                end
            end
            cks = model_sum();
            if ($urandom_range(0, 3) == 0) cks = cks ^ 8'(1 + $urandom_range(0, 254));
            send_frame(cks, $sformatf("rand%0d", n));
        end
        stall_prob = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
